// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, buffer depth,
// buffer entry layout and the modulo-BUF_DEPTH pointer step.
package insn_fetch_pkg;

  localparam int unsigned PC_BITS_DEF   = 6;
  localparam int unsigned INSN_BITS_DEF = 16;
  localparam int unsigned BUF_DEPTH     = 3;

  typedef struct packed {
    logic [INSN_BITS_DEF-1:0] insn;
    logic [PC_BITS_DEF-1:0]   pc;
  } entry_t;

  function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/insn_mem.sv
// Instruction memory: synchronous 1R1W array, one-cycle registered read.
// Contents are never cleared.
module insn_mem #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clka,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] r_rdata;

  always_ff @(posedge clka) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/insn_fetch.sv
// Fetch stage: issues memory reads at pc_in when a buffer slot is guaranteed and presents
// results over valid/ready. `define INSN_FETCH_PERF_EN adds fetch_cnt/stall_cnt outputs.
// Buffer entries use the package widths, so override PC_BITS/INSN_BITS together with the package.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int unsigned PC_BITS   = PC_BITS_DEF,
  parameter int unsigned INSN_BITS = INSN_BITS_DEF
) (
  input  logic                 clka,
  input  logic                 reset,
  input  logic                 run,
  input  logic [PC_BITS-1:0]   pc_in,
  output logic                 pc_advance,
  input  logic                 flush,
  input  logic                 ld_en,
  input  logic [PC_BITS-1:0]   ld_addr,
  input  logic [INSN_BITS-1:0] ld_data,
  output logic [INSN_BITS-1:0] insn,
  output logic [PC_BITS-1:0]   insn_pc,
  output logic                 insn_valid,
  input  logic                 insn_ready
`ifdef INSN_FETCH_PERF_EN
  ,
  output logic [15:0]          fetch_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  logic [1:0]           r_count, r_rd, r_wr;
  logic                 r_inflight;
  logic [PC_BITS-1:0]   r_tag;
  entry_t               r_buf [BUF_DEPTH];
  entry_t               r_head;

  logic [INSN_BITS-1:0] w_rdata;
  logic                 w_issue, w_push, w_pop;
  logic [1:0]           w_count_n, w_rd_n;
  entry_t               w_new, w_head_n;

  insn_mem #(
    .ADDR_BITS(PC_BITS),
    .DATA_BITS(INSN_BITS)
  ) u_mem (
    .clka    (clka),
    .i_we    (ld_en & ~reset),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_re    (w_issue),
    .i_raddr (pc_in),
    .o_rdata (w_rdata)
  );

  assign insn_valid = (r_count != '0);

  // Occupancy counts the in-flight read, so a completing read always finds a free slot.
  always_comb begin
    w_issue   = run & ~flush & ~ld_en & ~reset
              & (({1'b0, r_count} + {2'b00, r_inflight}) < 3'(BUF_DEPTH));
    w_pop     = insn_valid & insn_ready & ~flush;
    w_push    = r_inflight & ~flush;
    w_new     = '{insn: w_rdata, pc: r_tag};
    w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
    w_rd_n    = w_pop ? buf_ptr_inc(r_rd) : r_rd;
    // The new head comes straight from the read port when it lands in an empty buffer.
    w_head_n  = (w_push && (w_rd_n == r_wr)) ? w_new : r_buf[w_rd_n];
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag <= pc_in;
      if (flush) begin
        r_count <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
      end else begin
        if (w_push) begin
          r_buf[r_wr] <= w_new;
          r_wr        <= buf_ptr_inc(r_wr);
        end
        r_rd    <= w_rd_n;
        r_count <= w_count_n;
        if (w_count_n != '0) r_head <= w_head_n;
      end
    end
  end

  assign pc_advance = w_issue;
  assign insn       = r_head.insn;
  assign insn_pc    = r_head.pc;

`ifdef INSN_FETCH_PERF_EN
  logic [15:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clka) begin
    if (reset || flush) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (run && !w_issue && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: the bench plays the PC block and predicts outputs
// from an ordered queue of outstanding fetches plus a memory image.
module tb_insn_fetch;

  logic        clka = 1'b0;
  logic        reset, run, flush, ld_en, insn_ready;
  logic        pc_advance, insn_valid;
  logic [5:0]  pc_in, ld_addr, insn_pc;
  logic [15:0] ld_data, insn;
`ifdef INSN_FETCH_PERF_EN
  logic [15:0] fetch_cnt, stall_cnt;
  int          m_fetch, m_stall;
`endif

  always #5 clka = ~clka;

  insn_fetch dut (
    .clka       (clka),
    .reset      (reset),
    .run        (run),
    .pc_in      (pc_in),
    .pc_advance (pc_advance),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready)
`ifdef INSN_FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Reference: every fetch accepted but not yet consumed, oldest first, with its issue cycle.
  typedef struct {
    logic [15:0] insn;
    logic [5:0]  pc;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem_m [64];
  logic [15:0] last_insn;
  logic [5:0]  last_pc;
  int          cyc, checks, errors;
  logic        e_adv, e_valid;
  logic [15:0] e_insn;
  logic [5:0]  e_pc;

  task automatic settle();
    @(negedge clka);
    e_adv   = run & ~flush & ~ld_en & ~reset & (q.size() < 3);
    e_valid = 1'b0;
    if (q.size() > 0) e_valid = (cyc >= q[0].cyc + 2);
    e_insn  = e_valid ? q[0].insn : last_insn;
    e_pc    = e_valid ? q[0].pc   : last_pc;
  endtask

  task automatic advance();
    if (reset) begin
      q.delete();
      last_insn = '0;
      last_pc   = '0;
    end else begin
      if (e_valid) begin
        last_insn = e_insn;
        last_pc   = e_pc;
      end
      if (flush) q.delete();
      else if (e_valid && insn_ready) q.delete(0);
      if (e_adv) q.push_back('{mem_m[pc_in], pc_in, cyc});
      if (ld_en) mem_m[ld_addr] = ld_data;
    end
`ifdef INSN_FETCH_PERF_EN
    if (reset || flush) begin
      m_fetch = 0;
      m_stall = 0;
    end else begin
      if (e_adv && m_fetch < 65535) m_fetch++;
      if (run && !e_adv && m_stall < 65535) m_stall++;
    end
`endif
    cyc++;
    @(posedge clka);
    #1;
    if (e_adv) pc_in = pc_in + 6'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      settle();
      advance();
    end
    reset = 1'b0;
    settle();
    checks++;
    if ({pc_advance, insn_valid, insn, insn_pc} !== 24'h0) begin
      errors++;
      $display("FAIL reset got %b_%b_%h_%0d want all zero", pc_advance, insn_valid, insn, insn_pc);
    end
    advance();
  endtask

  task automatic test_load();
    for (int unsigned a = 0; a < 64; a++) begin
      ld_en   = 1'b1;
      ld_addr = 6'(a);
      ld_data = 16'hA000 + 16'(a);
      run     = 1'($urandom_range(0, 1));
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL load cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
      advance();
    end
    ld_en = 1'b0;
  endtask

  task automatic test_stream_wrap();
    int   first_adv = -1, first_valid = -1;
    logic prev_valid = 1'b0;
    logic [5:0] prev_pc = '0;
    pc_in = '0;
    run = 1'b1;
    insn_ready = 1'b1;
    for (int unsigned i = 0; i < 80; i++) begin
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL stream cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
      if (pc_advance && first_adv < 0) first_adv = cyc;
      if (insn_valid && first_valid < 0) first_valid = cyc;
      if (prev_valid && prev_pc == 6'd63) begin
        checks++;
        if (!insn_valid || insn_pc !== 6'd0 || insn !== 16'hA000) begin
          errors++;
          $display("FAIL wrap got v=%b pc=%0d insn=%h want v=1 pc=0 insn=a000", insn_valid, insn_pc, insn);
        end
      end
      prev_valid = insn_valid;
      prev_pc    = insn_pc;
      advance();
    end
    checks++;
    if (first_adv < 0 || first_valid - first_adv != 2) begin
      errors++;
      $display("FAIL first_latency got %0d want 2", first_valid - first_adv);
    end
  endtask

  task automatic test_backpressure();
    for (int unsigned i = 0; i < 25; i++) begin
      insn_ready = (i < 5 || i >= 15);
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL backpressure cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
      if (i >= 10 && i < 15) begin
        checks++;
        if (pc_advance !== 1'b0) begin
          errors++;
          $display("FAIL full_no_issue got adv=%b want 0", pc_advance);
        end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    logic found = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      insn_ready = (i != 4);
      flush      = (i == 5);
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL flush_setup cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
      advance();
    end
    flush = 1'b0;
    pc_in = 6'd20;
    settle();
    checks++;
    if (insn_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid got %b want 0", insn_valid);
    end
    advance();
    for (int unsigned i = 0; i < 8 && !found; i++) begin
      settle();
      if (insn_valid) begin
        found = 1'b1;
        checks++;
        if (insn_pc !== 6'd20 || insn !== 16'hA014) begin
          errors++;
          $display("FAIL flush_redirect got pc=%0d insn=%h want pc=20 insn=a014", insn_pc, insn);
        end
      end
      advance();
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL flush_redirect got no valid entry want pc=20 within 8 cycles");
    end
  endtask

  task automatic test_load_collision();
    logic found = 1'b0;
    pc_in   = 6'd7;
    ld_en   = 1'b1;
    ld_addr = 6'd7;
    ld_data = 16'h1234;
    settle();
    checks++;
    if (pc_advance !== 1'b0) begin
      errors++;
      $display("FAIL ld_block got adv=%b want 0", pc_advance);
    end
    advance();
    ld_en = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL ld_stream cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
      if (!found && insn_valid && insn_pc == 6'd7) begin
        found = 1'b1;
        checks++;
        if (insn !== 16'h1234) begin
          errors++;
          $display("FAIL ld_collision got insn=%h want 1234", insn);
        end
      end
      advance();
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL ld_collision got no pc=7 entry want insn=1234");
    end
  endtask

  task automatic test_reset_mid();
    insn_ready = 1'b0;
    repeat (6) begin
      settle();
      advance();
    end
    reset = 1'b1;
    run   = 1'b0;
    settle();
    checks++;
    if (pc_advance !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle_adv got %b want 0", pc_advance);
    end
    advance();
    reset = 1'b0;
    settle();
    checks++;
    if ({pc_advance, insn_valid, insn, insn_pc} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid got %b_%b_%h_%0d want all zero", pc_advance, insn_valid, insn, insn_pc);
    end
    advance();
    pc_in = '0;
    run = 1'b1;
    insn_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL reset_resume cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
      if (i == 2) begin
        checks++;
        if (!insn_valid || insn !== 16'hA000 || insn_pc !== 6'd0) begin
          errors++;
          $display("FAIL reset_mem got v=%b insn=%h pc=%0d want v=1 insn=a000 pc=0", insn_valid, insn, insn_pc);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 300; i++) begin
      run        = ($urandom_range(0, 7) != 0);
      insn_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      ld_en      = ($urandom_range(0, 15) == 0);
      ld_addr    = 6'($urandom);
      ld_data    = 16'($urandom);
      settle();
      checks++;
      if ({pc_advance, insn_valid, insn, insn_pc} !== {e_adv, e_valid, e_insn, e_pc}) begin
        errors++;
        $display("FAIL random cyc=%0d got %b_%b_%h_%0d want %b_%b_%h_%0d", cyc,
                 pc_advance, insn_valid, insn, insn_pc, e_adv, e_valid, e_insn, e_pc);
      end
`ifdef INSN_FETCH_PERF_EN
      checks++;
      if (fetch_cnt !== 16'(m_fetch) || stall_cnt !== 16'(m_stall)) begin
        errors++;
        $display("FAIL perf got %0d/%0d want %0d/%0d", fetch_cnt, stall_cnt, m_fetch, m_stall);
      end
`endif
      advance();
      if (flush) pc_in = 6'($urandom);
    end
    flush = 1'b0;
    ld_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; flush = 1'b0; ld_en = 1'b0; insn_ready = 1'b0;
    pc_in = '0; ld_addr = '0; ld_data = '0;
    cyc = 0; checks = 0; errors = 0;
    last_insn = '0; last_pc = '0;
`ifdef INSN_FETCH_PERF_EN
    m_fetch = 0; m_stall = 0;
`endif
    for (int unsigned a = 0; a < 64; a++) mem_m[a] = '0;
    test_reset();
    test_load();
    test_stream_wrap();
    test_backpressure();
    test_flush();
    test_load_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Fetch stage directly downstream of the PC block.
- Consumes the current PC value and owns the instruction memory (2^PC_BITS words).
- Presents fetched instructions to decode over a valid/ready handshake.
- Drives the PC's advance strobe, so the PC only steps when a fetch slot is guaranteed.

Parameters:
- PC_BITS, 6, width of PC and instruction-memory address.
- INSN_BITS, 16, instruction word width.
- BUF_DEPTH, 3, output buffer entries; fixed at 3, giving 1 instruction/cycle with 2-cycle read latency.

Ports:
- clka  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 = no new issues.
- pc_in  in  PC_BITS  current PC from the PC block.
- pc_advance  out  1  one-cycle strobe: PC block steps to its next value at this edge.
- flush  in  1  redirect: discard in-flight read and all buffered entries.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  PC_BITS  load address.
- ld_data  in  INSN_BITS  load data.
- insn  out  INSN_BITS  head-of-buffer instruction.
- insn_pc  out  PC_BITS  PC the head instruction was fetched from.
- insn_valid  out  1  head entry valid.
- insn_ready  in  1  decode accepts head entry this cycle.

Behaviour:
- Reset (sync, with priority over everything):
  - insn_valid=0, insn=0, insn_pc=0, pc_advance=0.
  - Buffer count=0, in-flight flag=0.
  - Memory contents are NOT cleared.
- Memory:
  - Synchronous write when ld_en=1.
  - Synchronous read: address at edge N, data available in cycle N+1.
- Issue condition, registered decision: issue = run & ~flush & ~ld_en & (count + inflight < BUF_DEPTH).
  - The condition uses registered count/inflight only; no combinational path from insn_ready to pc_advance.
- On issue at edge N:
  - Memory reads pc_in and pc_in is captured as the tag.
  - inflight set for cycle N+1.
  - pc_advance=1 during the issue cycle; it is a combinational function of registered state and the run, flush and ld_en inputs.
- At the edge ending the in-flight cycle, {data, tag} is pushed into the buffer tail. Earliest insn_valid is 2 cycles after the issue edge.
- Pop: insn_valid & insn_ready. Push and pop in the same cycle are allowed; count is unchanged.
- Steady state with run=1 and ready=1: one instruction per cycle after a 2-cycle fill.
- Buffer full (count=3): no issue, pc_advance=0. The in-flight read always has space by construction.
- flush=1 at edge:
  - count→0, inflight→0, insn_valid=0 next cycle.
  - No issue that cycle.
  - A pop in the same cycle is ignored; the entry is lost.
  - Fetch resumes the next cycle from the (redirected) pc_in.
- ld_en=1: blocks issue that cycle. An in-flight read still completes with the data read before the write; no forwarding.
- Simultaneous ld_en and flush: both take effect.
- run deasserted: no new issues; the in-flight read completes; buffer drains normally.
- Reset mid-stream: all in-flight and buffered instructions discarded; no pc_advance in the reset cycle.
- insn and insn_pc hold their last head value when insn_valid=0; they are 0 after reset.

Optional Feature:
- Macro: INSN_FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_cnt[15:0] (increments per issue) and stall_cnt[15:0] (increments per cycle with run=1 and no issue).
  - Both are cleared by reset or flush and saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: PC_BITS and INSN_BITS defaults, BUF_DEPTH, buffer entry struct {insn, pc}.
- Sub-module insn_mem: synchronous 1R1W array, clka, write port and read port with read-enable.
- Buffer/issue control stays in insn_fetch.

Test Plan:
- Load and stream:
  - Stimulus: load mem[a] = 16'hA000+a for a=0..63, then run=1, insn_ready=1, with the PC stepping on pc_advance from 0.
  - Response: insn_valid first rises 2 cycles after the first pc_advance; then one instruction per cycle, insn=16'hA000+k, insn_pc=k.
- Wrap-around:
  - Stimulus: continue the load-and-stream run past PC 63.
  - Response: after insn_pc=63 (insn=16'hA03F), the next entry is insn_pc=0, insn=16'hA000; no gap.
- Backpressure:
  - Stimulus: insn_ready=0 from cycle 5 onward.
  - Response: count reaches 3, pc_advance stays 0, head holds its value; releasing ready delivers the held entries in order with no loss or duplication.
- Flush:
  - Stimulus: flush=1 with count=2 and inflight=1, with pc_in redirected to 20 in the following cycle.
  - Response: insn_valid=0 the next cycle; the next delivered entry is insn_pc=20, insn=16'hA014.
- Load collision:
  - Stimulus: ld_en=1 writing mem[7]=16'h1234 while pc_in=7 and run=1.
  - Response: pc_advance=0 that cycle; the next issue at PC 7 returns 16'h1234.
- Reset mid-stream:
  - Stimulus: reset=1 for one cycle with count=3.
  - Response: insn_valid=0, insn=0, insn_pc=0, pc_advance=0 after the edge; memory still returns 16'hA000+a afterwards.
